// File: rtl/lsu_arbiter_if.sv
// Shared request/response types and the requester/LSU bundle used by lsu_arbiter.
// The arbiter drives the slave modport; requesters and the LSU sit on the master side.
package lsu_arbiter_pkg;
    typedef enum logic [1:0] {
        LSU_LOAD   = 2'd0,
        LSU_STORE  = 2'd1,
        LSU_LOCK   = 2'd2,
        LSU_INSERT = 2'd3
    } lsu_op_t;

    typedef struct packed {
        logic        val;
        lsu_op_t     lsu_op;
        logic [31:0] addr;
        logic [31:0] data;
    } header_data_req_t;

    typedef struct packed {
        logic        val;
        logic        err;
        logic [31:0] data;
    } header_data_rsp_t;
endpackage

interface lsu_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
);
    lsu_arbiter_pkg::header_data_req_t [NUM_REQ-1:0] req_i;
    logic [NUM_REQ-1:0]                              req_rdy_o;
    lsu_arbiter_pkg::header_data_rsp_t [NUM_REQ-1:0] rsp_o;
    logic [NUM_REQ-1:0]                              rsp_rdy_i;
    logic [NUM_REQ-1:0]                              lock_hold_i;
    lsu_arbiter_pkg::header_data_req_t               lsu_req_o;
    logic                                            lsu_ready_i;
    lsu_arbiter_pkg::header_data_rsp_t               lsu_rsp_i;
    logic                                            lsu_rsp_rdy_o;
    logic [IDX_W-1:0]                                grant_o;
    logic                                            busy_o;

    modport slave (
        input  req_i, rsp_rdy_i, lock_hold_i, lsu_ready_i, lsu_rsp_i,
        output req_rdy_o, rsp_o, lsu_req_o, lsu_rsp_rdy_o, grant_o, busy_o
    );

    modport master (
        output req_i, rsp_rdy_i, lock_hold_i, lsu_ready_i, lsu_rsp_i,
        input  req_rdy_o, rsp_o, lsu_req_o, lsu_rsp_rdy_o, grant_o, busy_o
    );
endinterface

// File: rtl/lsu_arbiter.sv
// Round-robin arbiter sharing one LSU among NUM_REQ requesters, one transaction in flight.
// Define LSU_ARB_LOCK_HOLD_EN to let the owner keep the LSU across transactions via lock_hold_i.
module lsu_arbiter
    import lsu_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    lsu_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_WAIT_RSP = 2'd2
`ifdef LSU_ARB_LOCK_HOLD_EN
        , ST_HOLD   = 2'd3
`endif
    } state_t;

    state_t                          state_r;
    logic [IDX_W-1:0]                grant_r;
    logic [IDX_W-1:0]                last_grant_r;
    header_data_req_t                lsu_req_r;

    logic                            pick_val_s;
    logic [IDX_W-1:0]                pick_idx_s;
    logic                            accept_s;
    logic [IDX_W-1:0]                acc_idx_s;
    logic [NUM_REQ-1:0]              req_rdy_s;
    header_data_req_t                acc_req_s;
    header_data_rsp_t [NUM_REQ-1:0]  rsp_s;
    logic                            lsu_rsp_rdy_s;
    logic                            rsp_done_s;
    logic                            hold_s;

`ifdef LSU_ARB_LOCK_HOLD_EN
    assign hold_s = bus.lock_hold_i[grant_r];
`else
    logic lock_hold_unused_s;
    assign lock_hold_unused_s = ^bus.lock_hold_i;
    assign hold_s = 1'b0;
`endif

    // Round-robin search from last_grant+1; iterating backwards lets the nearest candidate win.
    always_comb begin
        pick_val_s = 1'b0;
        pick_idx_s = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            pick_idx_s = bus.req_i[IDX_W'((int'(last_grant_r) + i) % NUM_REQ)].val
                         ? IDX_W'((int'(last_grant_r) + i) % NUM_REQ) : pick_idx_s;
            pick_val_s = pick_val_s | bus.req_i[IDX_W'((int'(last_grant_r) + i) % NUM_REQ)].val;
        end
    end

    // Acceptance: any requester in IDLE, only the lock owner in HOLD.
    always_comb begin
        accept_s  = 1'b0;
        acc_idx_s = pick_idx_s;
        req_rdy_s = '0;
        case (state_r)
            ST_IDLE: begin
                accept_s  = pick_val_s;
                acc_idx_s = pick_idx_s;
            end
`ifdef LSU_ARB_LOCK_HOLD_EN
            ST_HOLD: begin
                accept_s  = bus.req_i[grant_r].val;
                acc_idx_s = grant_r;
            end
`endif
            default: begin
                accept_s  = 1'b0;
                acc_idx_s = pick_idx_s;
            end
        endcase
        req_rdy_s[acc_idx_s] = accept_s;
        acc_req_s            = bus.req_i[acc_idx_s];
        acc_req_s.val        = 1'b1;
    end

    // Response path is a zero-latency pass-through to the owner only.
    always_comb begin
        rsp_s         = '0;
        lsu_rsp_rdy_s = 1'b0;
        if (state_r == ST_WAIT_RSP) begin
            rsp_s[grant_r] = bus.lsu_rsp_i;
            lsu_rsp_rdy_s  = bus.rsp_rdy_i[grant_r];
        end else begin
            rsp_s         = '0;
            lsu_rsp_rdy_s = 1'b0;
        end
    end

    assign rsp_done_s = (state_r == ST_WAIT_RSP) & bus.lsu_rsp_i.val & bus.rsp_rdy_i[grant_r];

    // Transaction FSM; lsu_req_r doubles as the latched request and the registered LSU output.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r      <= ST_IDLE;
            grant_r      <= '0;
            last_grant_r <= IDX_W'(NUM_REQ - 1);
            lsu_req_r    <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        lsu_req_r    <= acc_req_s;
                        grant_r      <= acc_idx_s;
                        last_grant_r <= acc_idx_s;
                        state_r      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (bus.lsu_ready_i) begin
                        lsu_req_r.val <= 1'b0;
                        state_r       <= ST_WAIT_RSP;
                    end
                end
                ST_WAIT_RSP: begin
                    if (rsp_done_s) begin
`ifdef LSU_ARB_LOCK_HOLD_EN
                        state_r <= hold_s ? ST_HOLD : ST_IDLE;
`else
                        state_r <= hold_s ? ST_WAIT_RSP : ST_IDLE;
`endif
                    end
                end
`ifdef LSU_ARB_LOCK_HOLD_EN
                ST_HOLD: begin
                    if (accept_s) begin
                        lsu_req_r <= acc_req_s;
                        state_r   <= ST_ISSUE;
                    end else if (!bus.lock_hold_i[grant_r]) begin
                        state_r <= ST_IDLE;
                    end
                end
`endif
                default: begin
                    state_r   <= ST_IDLE;
                    lsu_req_r <= '0;
                end
            endcase
        end
    end

    assign bus.req_rdy_o     = req_rdy_s;
    assign bus.rsp_o         = rsp_s;
    assign bus.lsu_rsp_rdy_o = lsu_rsp_rdy_s;
    assign bus.lsu_req_o     = lsu_req_r;
    assign bus.grant_o       = grant_r;
    assign bus.busy_o        = (state_r != ST_IDLE);

endmodule

// File: tb/tb_lsu_arbiter.sv
// Directed bench for lsu_arbiter with NUM_REQ=2; covers both builds of LSU_ARB_LOCK_HOLD_EN.
module tb_lsu_arbiter;
    import lsu_arbiter_pkg::*;

    logic clk_i = 1'b0;
    logic rst_i;
    int   n_tests = 0;
    int   n_fail  = 0;

    lsu_arbiter_if #(.NUM_REQ(2)) bus ();

    lsu_arbiter #(.NUM_REQ(2)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic set_req(input int k, input logic v, input lsu_op_t op, input logic [31:0] a);
        bus.req_i[k] = '{val: v, lsu_op: op, addr: a, data: 32'h0};
    endtask

    task automatic clear_rsp();
        bus.lsu_rsp_i = '0;
        bus.rsp_rdy_i = 2'b00;
    endtask

    // One full transaction with no stalls, starting in IDLE (or HOLD).
    task automatic run_txn(input string tag, input logic [1:0] exp_rdy, input int exp_g,
                           input logic [31:0] exp_addr);
        #1;
        chk({tag, "_rdy"}, 64'(bus.req_rdy_o), 64'(exp_rdy));
        tick();
        chk({tag, "_grant"}, 64'(bus.grant_o), 64'(exp_g));
        chk({tag, "_addr"}, 64'(bus.lsu_req_o.addr), 64'(exp_addr));
        chk({tag, "_lsuval"}, 64'(bus.lsu_req_o.val), 64'h1);
        chk({tag, "_busy_rdy"}, 64'(bus.req_rdy_o), 64'h0);
        bus.lsu_ready_i = 1'b1;
        tick();
        bus.lsu_ready_i = 1'b0;
        bus.lsu_rsp_i   = '{val: 1'b1, err: 1'b0, data: 32'hD000_0000 | exp_addr};
        bus.rsp_rdy_i   = 2'b11;
        #1;
        chk({tag, "_rspdata"}, 64'(bus.rsp_o[exp_g].data), 64'(32'hD000_0000 | exp_addr));
        tick();
        clear_rsp();
    endtask

    initial begin
        rst_i           = 1'b1;
        bus.req_i       = '0;
        bus.lock_hold_i = 2'b00;
        bus.lsu_ready_i = 1'b0;
        bus.lsu_rsp_i   = '{val: 1'b1, err: 1'b0, data: 32'hFFFF_FFFF};
        bus.rsp_rdy_i   = 2'b11;
        tick();
        tick();
        chk("rst_busy", 64'(bus.busy_o), 64'h0);
        chk("rst_grant", 64'(bus.grant_o), 64'h0);
        chk("rst_lsuval", 64'(bus.lsu_req_o.val), 64'h0);
        chk("rst_rspval", 64'({bus.rsp_o[1].val, bus.rsp_o[0].val}), 64'h0);
        chk("rst_lsurdy", 64'(bus.lsu_rsp_rdy_o), 64'h0);
        clear_rsp();
        rst_i = 1'b0;

        // Both request: 0 wins first; ISSUE stalls for 5 cycles.
        set_req(0, 1'b1, LSU_LOAD, 32'h100);
        set_req(1, 1'b1, LSU_LOAD, 32'h200);
        #1;
        chk("first_rdy", 64'(bus.req_rdy_o), 64'h1);
        tick();
        chk("first_grant", 64'(bus.grant_o), 64'h0);
        chk("first_busy", 64'(bus.busy_o), 64'h1);
        for (int c = 0; c < 5; c++) begin
            chk("stall_val", 64'(bus.lsu_req_o.val), 64'h1);
            chk("stall_addr", 64'(bus.lsu_req_o.addr), 64'h100);
            chk("stall_rdy", 64'(bus.req_rdy_o), 64'h0);
            tick();
        end
        bus.lsu_ready_i = 1'b1;
        #1;
        chk("issue_val", 64'(bus.lsu_req_o.val), 64'h1);
        tick();
        bus.lsu_ready_i = 1'b0;
        chk("wait_lsuval", 64'(bus.lsu_req_o.val), 64'h0);

        // Response held back by the requester for 3 cycles.
        bus.lsu_rsp_i = '{val: 1'b1, err: 1'b0, data: 32'hA5A5_0001};
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("bp_lsurdy", 64'(bus.lsu_rsp_rdy_o), 64'h0);
            chk("bp_rspval", 64'({bus.rsp_o[1].val, bus.rsp_o[0].val}), 64'h1);
            chk("bp_busy", 64'(bus.busy_o), 64'h1);
            tick();
        end
        bus.rsp_rdy_i = 2'b01;
        #1;
        chk("bp_done_rdy", 64'(bus.lsu_rsp_rdy_o), 64'h1);
        chk("bp_done_data", 64'(bus.rsp_o[0].data), 64'hA5A5_0001);
        tick();
        clear_rsp();
        chk("idle_busy", 64'(bus.busy_o), 64'h0);

        // Continuous requests rotate the grant: 0 (above), 1, 0.
        run_txn("rr1", 2'b10, 1, 32'h200);
        run_txn("rr2", 2'b01, 0, 32'h100);

        // Requester 1 appears and vanishes while busy: never granted.
        set_req(1, 1'b0, LSU_LOAD, 32'h200);
        #1;
        chk("solo_rdy", 64'(bus.req_rdy_o), 64'h1);
        tick();
        set_req(1, 1'b1, LSU_LOAD, 32'h200);
        #1;
        chk("outstanding_rdy", 64'(bus.req_rdy_o), 64'h0);
        bus.lsu_ready_i = 1'b1;
        tick();
        bus.lsu_ready_i = 1'b0;
        set_req(1, 1'b0, LSU_LOAD, 32'h200);
        bus.lsu_rsp_i   = '{val: 1'b1, err: 1'b0, data: 32'h0};
        bus.rsp_rdy_i   = 2'b11;
        tick();
        clear_rsp();
        #1;
        chk("drop_rdy", 64'(bus.req_rdy_o), 64'h1);
        chk("drop_grant", 64'(bus.grant_o), 64'h0);
        set_req(0, 1'b0, LSU_LOAD, 32'h100);
        set_req(1, 1'b1, LSU_LOAD, 32'h200);
        run_txn("r1solo", 2'b10, 1, 32'h200);

        // Locked sequence from requester 0 while 1 waits.
        set_req(0, 1'b1, LSU_LOCK, 32'h400);
        bus.lock_hold_i = 2'b01;
        run_txn("lock", 2'b01, 0, 32'h400);
        set_req(0, 1'b1, LSU_INSERT, 32'h404);
`ifdef LSU_ARB_LOCK_HOLD_EN
        #1;
        chk("hold_busy", 64'(bus.busy_o), 64'h1);
        run_txn("insert", 2'b01, 0, 32'h404);
        set_req(0, 1'b0, LSU_LOAD, 32'h0);
        #1;
        chk("hold_idle_rdy", 64'(bus.req_rdy_o), 64'h0);
        tick();
        chk("hold_stay", 64'(bus.busy_o), 64'h1);
        bus.lock_hold_i = 2'b00;
        tick();
        chk("hold_release", 64'(bus.busy_o), 64'h0);
        run_txn("after_lock", 2'b10, 1, 32'h200);
`else
        run_txn("nolock", 2'b10, 1, 32'h200);
        bus.lock_hold_i = 2'b00;
`endif

        // Reset in WAIT_RSP abandons the response and restarts arbitration at 0.
        set_req(0, 1'b1, LSU_LOAD, 32'h500);
        set_req(1, 1'b1, LSU_LOAD, 32'h600);
        #1;
        chk("pre_rst_rdy", 64'(bus.req_rdy_o), 64'h1);
        tick();
        bus.lsu_ready_i = 1'b1;
        tick();
        bus.lsu_ready_i = 1'b0;
        bus.lsu_rsp_i   = '{val: 1'b1, err: 1'b0, data: 32'h1234_5678};
        bus.rsp_rdy_i   = 2'b00;
        #1;
        chk("pre_rst_rsp", 64'(bus.rsp_o[0].val), 64'h1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        #1;
        chk("mid_rst_busy", 64'(bus.busy_o), 64'h0);
        chk("mid_rst_rspval", 64'({bus.rsp_o[1].val, bus.rsp_o[0].val}), 64'h0);
        chk("mid_rst_lsuval", 64'(bus.lsu_req_o.val), 64'h0);
        chk("mid_rst_rdy", 64'(bus.req_rdy_o), 64'h1);
        tick();
        chk("mid_rst_grant", 64'(bus.grant_o), 64'h0);
        chk("mid_rst_addr", 64'(bus.lsu_req_o.addr), 64'h500);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
